// File: rtl/data_memory_mc.sv
// Multi-cycle 16-bit word data memory with a fixed-latency handshaked response.
// One request outstanding at a time; a down-counter times the WAIT phase.
module data_memory_mc #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        enable,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 15;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CNT_W-1:0]      counter;
    logic [WORD_W-1:0]     lat_word;
    logic [15:0]           lat_data;
    logic                  lat_wr;
    logic [15:0]           mem [DEPTH];
    logic                  accept_c;
    logic                  commit_c;
    logic                  out_of_range_c;
    logic [DEPTH_LOG2-1:0] index_c;
    logic                  addr_lsb_unused;

    // Byte address bit 0 never selects anything: odd addresses alias the even word.
    assign addr_lsb_unused = addr[0];

    assign index_c        = lat_word[DEPTH_LOG2-1:0];
    assign out_of_range_c = (lat_word >> DEPTH_LOG2) != '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; accept in IDLE, commit on the edge that enters RESP.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT;
                    accept_c   = 1'b1;
                end
            end
            WAIT: begin
                if (counter == '0) begin
                    state_next = RESP;
                    commit_c   = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, latency counter and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            lat_word   <= '0;
            lat_data   <= '0;
            lat_wr     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            busy       <= (state_next != IDLE);
            data_valid <= commit_c;
            err        <= commit_c && out_of_range_c;
            if (accept_c) begin
                counter  <= CNT_W'(LATENCY - 1);
                lat_word <= addr[15:1];
                lat_data <= data_in;
                lat_wr   <= wr;
            end else if ((state == WAIT) && (counter != '0)) begin
                counter <= counter - CNT_W'(1);
            end
            if (commit_c && !lat_wr) begin
                data_out <= out_of_range_c ? 16'h0000 : mem[index_c];
            end
        end
    end

    // Storage array; not reset, written only for in-range writes at commit.
    always_ff @(posedge clk) begin
        if (commit_c && lat_wr && !out_of_range_c) begin
            mem[index_c] <= lat_data;
        end
    end

endmodule

// File: tb/tb_data_memory_mc.sv
// Bench for data_memory_mc: scoreboard of expected responses plus per-scenario tasks.
module tb_data_memory_mc;

    localparam int unsigned LAT = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr, data_in, data_out;
    logic        enable, wr, data_valid, busy, err;
    logic [15:0] a1, d1, dout1;
    logic        en1, wr1, dv1, busy1, err1;

    data_memory_mc #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .enable(enable), .wr(wr), .data_out(data_out),
        .data_valid(data_valid), .busy(busy), .err(err)
    );

    data_memory_mc #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(a1), .data_in(d1),
        .enable(en1), .wr(wr1), .data_out(dout1),
        .data_valid(dv1), .busy(busy1), .err(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic [15:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model[int];
    logic [15:0] last_rd = 16'h0000;

    // Scoreboard: every response pops one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && data_valid) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: data_valid with nothing outstanding at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                if (e.rd) last_rd = e.data;
                n_chk++;
                if (data_out !== last_rd) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h exp %h (cycle %0d)", data_out, last_rd, cyc);
                end
                n_chk++;
                if (err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_err: got %b exp %b (cycle %0d)", err, e.err, cyc);
                end
                n_chk++;
                if (cyc - e.acc != int'(LAT)) begin
                    n_fail++;
                    $display("FAIL sb_latency: got %0d exp %0d", cyc - e.acc, LAT);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || sbq.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (busy || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b outstanding=%0d after %0d cycles", busy, sbq.size(), n);
        end
    endtask

    // Drive one request from IDLE and record what the response must be.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        exp_t        e;
        logic [15:0] la;
        logic        oor;
        int          idx;
        wait_idle();
        la    = a;
        oor   = (la >> 11) != 16'h0000;
        idx   = int'(la[10:1]);
        e.rd  = !w;
        e.err = oor;
        e.data = (!w && !oor) ? model[idx] : 16'h0000;
        if (w && !oor) model[idx] = d;
        addr = a; data_in = d; wr = w; enable = 1'b1;
        @(posedge clk); #1;
        e.acc = cyc;
        sbq.push_back(e);
        enable = 1'b0;
    endtask

    task automatic test_reset();
        addr = '0; data_in = '0; wr = 1'b0; enable = 1'b0;
        a1 = '0; d1 = '0; wr1 = 1'b0; en1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", data_valid); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", err); end
        n_chk++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %h exp 0000", data_out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        issue(1'b1, 16'h0010, 16'hBEEF);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b exp 1", busy); end
        issue(1'b0, 16'h0010, 16'h0000);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int   nb;
        exp_t e;
        issue(1'b1, 16'h0000, 16'hA0A0);
        issue(1'b1, 16'h0002, 16'hB1B1);
        wait_idle();
        addr = 16'h0000; wr = 1'b0; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e.rd = 1'b1; e.err = 1'b0; e.data = model[int'(addr[10:1])]; e.acc = cyc + 1;
            sbq.push_back(e);
            @(posedge clk); #1;
            n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: req %0d got %b exp 1", k, busy); end
            addr = addr ^ 16'h0002;
            nb = 0;
            while (busy && nb < 20) begin
                @(posedge clk); #1;
                nb++;
            end
            n_chk++; if (nb != int'(LAT) + 1) begin n_fail++; $display("FAIL b2b_period: req %0d got %0d exp %0d", k, nb, LAT + 1); end
        end
        enable = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b exp 0", busy); end
    endtask

    task automatic test_wait_ignore();
        issue(1'b1, 16'h0022, 16'h7777);
        issue(1'b1, 16'h0020, 16'h1234);
        addr = 16'h0022; data_in = 16'h5555; wr = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        enable = 1'b0;
        issue(1'b0, 16'h0020, 16'h0000);
        issue(1'b0, 16'h0022, 16'h0000);
        wait_idle();
    endtask

    task automatic test_out_of_range();
        issue(1'b1, 16'h0800, 16'hAAAA);
        issue(1'b0, 16'h0800, 16'h0000);
        issue(1'b0, 16'h0000, 16'h0000);
        wait_idle();
    endtask

    task automatic test_reset_abort();
        issue(1'b1, 16'h0004, 16'h1111);
        issue(1'b0, 16'h0000, 16'h0000);
        wait_idle();
        addr = 16'h0004; data_in = 16'h2222; wr = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", busy); end
        n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b exp 0", data_valid); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b exp 0", err); end
        n_chk++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL abort_data: got %h exp 0000", data_out); end
        last_rd = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 16'h0004, 16'h0000);
        wait_idle();
    endtask

    task automatic test_latency1();
        a1 = 16'h0003; d1 = 16'h0F0F; wr1 = 1'b1; en1 = 1'b1;
        @(posedge clk); #1;
        en1 = 1'b0;
        n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL l1_busy: got %b exp 1", busy1); end
        n_chk++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL l1_early: got %b exp 0", dv1); end
        @(posedge clk); #1;
        n_chk++; if (dv1 !== 1'b1) begin n_fail++; $display("FAIL l1_wr_valid: got %b exp 1", dv1); end
        n_chk++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL l1_wr_err: got %b exp 0", err1); end
        n_chk++; if (dout1 !== 16'h0000) begin n_fail++; $display("FAIL l1_wr_data: got %h exp 0000", dout1); end
        @(posedge clk); #1;
        n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL l1_idle: got %b exp 0", busy1); end
        n_chk++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL l1_pulse: got %b exp 0", dv1); end
        a1 = 16'h0002; wr1 = 1'b0; en1 = 1'b1;
        @(posedge clk); #1;
        en1 = 1'b0;
        n_chk++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL l1_rd_early: got %b exp 0", dv1); end
        @(posedge clk); #1;
        n_chk++; if (dv1 !== 1'b1) begin n_fail++; $display("FAIL l1_rd_valid: got %b exp 1", dv1); end
        n_chk++; if (dout1 !== 16'h0F0F) begin n_fail++; $display("FAIL l1_rd_data: got %h exp 0f0f", dout1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wait_ignore();
        test_out_of_range();
        test_reset_abort();
        test_latency1();
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding exp 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
